// File: rtl/gate_pkg.sv
// Shared constants for the gate-reduction pipeline: operation encodings and mode width.
package gate_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_AND  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_OR   = 3'b001;
    localparam logic [MODE_W-1:0] MODE_XOR  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_NAND = 3'b011;
    localparam logic [MODE_W-1:0] MODE_NOR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_XNOR = 3'b101;

endpackage

// File: rtl/reduce_core.sv
// Purely combinational N_IN-bit reduction; codes 110/111 give y=0 and flag err.
module reduce_core
    import gate_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0]   data,
    input  logic [MODE_W-1:0] mode,
    output logic              y,
    output logic              err
);

    // Select the reduction operator for the requested mode.
    always_comb begin
        y   = 1'b0;
        err = 1'b0;
        case (mode)
            MODE_AND:  y = &data;
            MODE_OR:   y = |data;
            MODE_XOR:  y = ^data;
            MODE_NAND: y = ~&data;
            MODE_NOR:  y = ~|data;
            MODE_XNOR: y = ~^data;
            default: begin
                y   = 1'b0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/reduce_gate_pipe.sv
// One-stage valid/ready pipeline around reduce_core, with a saturating count of delivered hits.
module reduce_gate_pipe
    import gate_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    input  logic [MODE_W-1:0] mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic              out_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             core_y_s;
    logic             core_err_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             out_valid_d, out_valid_q;
    logic             out_y_d,     out_y_q;
    logic             out_err_d,   out_err_q;
    logic [CNT_W-1:0] hit_cnt_d,   hit_cnt_q;

    reduce_core #(.N_IN(N_IN)) u_core (
        .data (in_data),
        .mode (mode),
        .y    (core_y_s),
        .err  (core_err_s)
    );

    // The slot can take new data whenever it is empty or being drained this cycle.
    assign in_ready   = !out_valid_q || out_ready;
    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid_q && out_ready;

    // Output slot: load on input transfer, empty on a lone output transfer, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_err_d   = out_err_q;
        if (in_xfer_s) begin
            out_valid_d = 1'b1;
            out_y_d     = core_y_s;
            out_err_d   = core_err_s;
        end else if (out_xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Hit counter: clear wins over increment; increment stops at all-ones.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d = {CNT_W{1'b0}};
        end else if (out_xfer_s && out_y_q && !out_err_q && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_ONE;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_err_q   <= 1'b0;
            hit_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_err_q   <= out_err_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_err   = out_err_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed bench for reduce_gate_pipe: 3-bit, 8-bit and 4-bit-counter instances.
module tb_reduce_gate_pipe;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] data;
        logic       exp_y;
        logic       exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Instance a: N_IN=3, CNT_W=16
    logic        va, ra, ira, ova, ya, ea, ca;
    logic [2:0]  da, ma;
    logic [15:0] ha;
    // Instance b: N_IN=8, CNT_W=16
    logic        vb, rb, irb, ovb, yb, eb, cb;
    logic [7:0]  db;
    logic [2:0]  mb;
    logic [15:0] hb;
    // Instance c: N_IN=3, CNT_W=4
    logic        vc, rc, irc, ovc, yc, ec, cc;
    logic [2:0]  dc, mc;
    logic [3:0]  hc;

    reduce_gate_pipe #(.N_IN(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ira), .in_data(da), .mode(ma),
        .out_valid(ova), .out_ready(ra), .out_y(ya), .out_err(ea), .cnt_clr(ca), .hit_cnt(ha));
    reduce_gate_pipe #(.N_IN(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(irb), .in_data(db), .mode(mb),
        .out_valid(ovb), .out_ready(rb), .out_y(yb), .out_err(eb), .cnt_clr(cb), .hit_cnt(hb));
    reduce_gate_pipe #(.N_IN(3), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(irc), .in_data(dc), .mode(mc),
        .out_valid(ovc), .out_ready(rc), .out_y(yc), .out_err(ec), .cnt_clr(cc), .hit_cnt(hc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tab_a[14];
    vec_t tab_b[6];

    initial begin
        checks = 0;
        errors = 0;
        // 3-bit vectors, hand-evaluated
        tab_a[0]  = '{3'b000, 8'h07, 1'b1, 1'b0};
        tab_a[1]  = '{3'b000, 8'h06, 1'b0, 1'b0};
        tab_a[2]  = '{3'b001, 8'h00, 1'b0, 1'b0};
        tab_a[3]  = '{3'b001, 8'h04, 1'b1, 1'b0};
        tab_a[4]  = '{3'b010, 8'h05, 1'b0, 1'b0};
        tab_a[5]  = '{3'b010, 8'h04, 1'b1, 1'b0};
        tab_a[6]  = '{3'b011, 8'h07, 1'b0, 1'b0};
        tab_a[7]  = '{3'b011, 8'h03, 1'b1, 1'b0};
        tab_a[8]  = '{3'b100, 8'h00, 1'b1, 1'b0};
        tab_a[9]  = '{3'b100, 8'h02, 1'b0, 1'b0};
        tab_a[10] = '{3'b101, 8'h07, 1'b0, 1'b0};
        tab_a[11] = '{3'b101, 8'h06, 1'b1, 1'b0};
        tab_a[12] = '{3'b110, 8'h07, 1'b0, 1'b1};
        tab_a[13] = '{3'b111, 8'h07, 1'b0, 1'b1};
        // 8-bit vectors
        tab_b[0] = '{3'b010, 8'hA7, 1'b1, 1'b0};
        tab_b[1] = '{3'b011, 8'hFF, 1'b0, 1'b0};
        tab_b[2] = '{3'b100, 8'h00, 1'b1, 1'b0};
        tab_b[3] = '{3'b000, 8'hFF, 1'b1, 1'b0};
        tab_b[4] = '{3'b001, 8'h00, 1'b0, 1'b0};
        tab_b[5] = '{3'b101, 8'hA7, 1'b0, 1'b0};

        va = 1'b0; ra = 1'b1; da = 3'b000; ma = 3'b000; ca = 1'b0;
        vb = 1'b0; rb = 1'b1; db = 8'h00;  mb = 3'b000; cb = 1'b0;
        vc = 1'b0; rc = 1'b1; dc = 3'b000; mc = 3'b000; cc = 1'b0;
        rst_n = 1'b0;

        #3;
        chk("reset_in_ready", {31'd0, ira}, 32'd1);
        chk("reset_out_valid", {31'd0, ova}, 32'd0);
        chk("reset_hit_cnt", {16'd0, ha}, 32'd0);
        #9 rst_n = 1'b1;
        step();
        chk("post_reset_in_ready", {31'd0, ira}, 32'd1);
        chk("post_reset_no_xfer", {31'd0, ova}, 32'd0);

        // OR over 000 then 100, one cycle latency each
        va = 1'b1; ma = 3'b001; da = 3'b000;
        step();
        chk("or000_valid", {31'd0, ova}, 32'd1);
        chk("or000_y", {31'd0, ya}, 32'd0);
        da = 3'b100;
        step();
        chk("or100_y", {31'd0, ya}, 32'd1);
        chk("or100_hit_before", {16'd0, ha}, 32'd0);
        va = 1'b0;
        step();
        chk("or_drain_valid", {31'd0, ova}, 32'd0);
        chk("or_hit_cnt", {16'd0, ha}, 32'd1);

        // Back-to-back table on 3-bit instance
        for (int i = 0; i < 14; i++) begin
            va = 1'b1; ma = tab_a[i].mode; da = tab_a[i].data[2:0];
            step();
            chk($sformatf("a%0d_valid", i), {31'd0, ova}, 32'd1);
            chk($sformatf("a%0d_y", i), {31'd0, ya}, {31'd0, tab_a[i].exp_y});
            chk($sformatf("a%0d_err", i), {31'd0, ea}, {31'd0, tab_a[i].exp_err});
        end
        va = 1'b0;
        step();
        chk("a_table_drain_valid", {31'd0, ova}, 32'd0);
        chk("a_table_hit_cnt", {16'd0, ha}, 32'd7);

        // Table on 8-bit instance
        for (int i = 0; i < 6; i++) begin
            vb = 1'b1; mb = tab_b[i].mode; db = tab_b[i].data;
            step();
            chk($sformatf("b%0d_y", i), {31'd0, yb}, {31'd0, tab_b[i].exp_y});
            chk($sformatf("b%0d_err", i), {31'd0, eb}, {31'd0, tab_b[i].exp_err});
        end
        vb = 1'b0;
        step();
        chk("b_hit_cnt", {16'd0, hb}, 32'd3);

        // Backpressure: result held while inputs change
        va = 1'b1; ra = 1'b0; ma = 3'b000; da = 3'b111;
        step();
        chk("bp_load_y", {31'd0, ya}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            da = 3'(i);
            ma = (i == 2) ? 3'b111 : 3'b001;
            #1;
            chk($sformatf("bp%0d_in_ready", i), {31'd0, ira}, 32'd0);
            step();
            chk($sformatf("bp%0d_y", i), {31'd0, ya}, 32'd1);
            chk($sformatf("bp%0d_err", i), {31'd0, ea}, 32'd0);
            chk($sformatf("bp%0d_valid", i), {31'd0, ova}, 32'd1);
        end
        chk("bp_hit_held", {16'd0, ha}, 32'd7);
        va = 1'b0; ra = 1'b1;
        step();
        chk("bp_release_valid", {31'd0, ova}, 32'd0);
        chk("bp_release_hit", {16'd0, ha}, 32'd8);

        // Saturation on 4-bit counter: 20 back-to-back OR hits
        vc = 1'b1; mc = 3'b001; dc = 3'b001;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 15) chk("sat_at_15", {28'd0, hc}, 32'd15);
        end
        chk("sat_final", {28'd0, hc}, 32'd15);
        cc = 1'b1;
        step();
        chk("clr_priority_sat", {28'd0, hc}, 32'd0);
        cc = 1'b0;
        step();
        chk("inc_after_clr", {28'd0, hc}, 32'd1);
        cc = 1'b1;
        step();
        chk("clr_priority_inc", {28'd0, hc}, 32'd0);
        cc = 1'b0; vc = 1'b0;
        step();

        // Asynchronous reset while a result is held
        va = 1'b1; ra = 1'b0; ma = 3'b000; da = 3'b111;
        step();
        chk("pre_rst_valid", {31'd0, ova}, 32'd1);
        chk("pre_rst_hit", {16'd0, ha}, 32'd8);
        va = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, ova}, 32'd0);
        chk("async_rst_y", {31'd0, ya}, 32'd0);
        chk("async_rst_hit", {16'd0, ha}, 32'd0);
        chk("async_rst_in_ready", {31'd0, ira}, 32'd1);
        #4 rst_n = 1'b1;
        step();
        chk("after_rst_no_xfer", {31'd0, ova}, 32'd0);
        chk("after_rst_in_ready", {31'd0, ira}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reduce_gate_pipe.md
REDUCE_GATE_PIPE -- requirements
Module: reduce_gate_pipe

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, number of input bits reduced per transaction; legal range 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the saturating hit counter; legal range 4..32.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  input transaction present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept the input transaction.
REQ-007 The block SHALL have port in_data  input  N_IN  operand bits.
REQ-008 The block SHALL have port mode  input  3  operation: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 illegal.
REQ-009 The block SHALL have port out_valid  output  1  result held in the output register.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 The block SHALL have port out_y  output  1  reduction result.
REQ-012 The block SHALL have port out_err  output  1  result was produced from an illegal mode.
REQ-013 The block SHALL have port cnt_clr  input  1  synchronous clear of hit_cnt.
REQ-014 The block SHALL have port hit_cnt  output  CNT_W  count of delivered results with out_y=1 and out_err=0.

Function
REQ-015 An input transfer SHALL occur on a clock edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally; in_ready SHALL NOT depend on in_valid.
REQ-017 On an input transfer the result of mode applied across all N_IN bits of in_data SHALL be registered into out_y, with out_valid=1 on the next cycle (latency 1).
REQ-018 mode and in_data SHALL be sampled only at the input transfer; changes while out_valid=1 and no transfer SHALL NOT alter out_y or out_err.
REQ-019 Illegal mode (110/111) SHALL produce out_y=0 and out_err=1; legal modes SHALL produce out_err=0.
REQ-020 While out_valid=1 and out_ready=0, out_y and out_err SHALL hold stable.
REQ-021 Simultaneous output and input transfers in one cycle SHALL load the new result with out_valid staying 1 (full throughput, one result per cycle).
REQ-022 An output transfer with no input transfer SHALL clear out_valid on the next cycle.
REQ-023 hit_cnt SHALL increment by 1 on each output transfer with out_y=1 and out_err=0.
REQ-024 hit_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-025 cnt_clr=1 SHALL set hit_cnt to 0 on the next edge, taking priority over a simultaneous increment.
REQ-026 The reduction path SHALL be purely combinational between in_data and the output register; no other pipeline stage SHALL exist.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately force out_valid=0, out_y=0, out_err=0, hit_cnt=0, independent of clk.
REQ-028 Reset mid-transaction SHALL discard any held result; no transfer SHALL be reported on the first edge after deassertion unless in_valid is 1 at that edge.
REQ-029 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-030 Mode encodings (MODE_AND..MODE_XNOR) and the mode width SHALL be defined as constants in shared package gate_pkg.
REQ-031 The combinational N_IN-bit reduction SHALL be a sub-module reduce_core (inputs data, mode; outputs y, err), instantiated once.
REQ-032 Handshake, output register and counter SHALL reside in reduce_gate_pipe.

Verification
REQ-033 N_IN=3, mode=001, in_data=3'b000 then 3'b100, out_ready=1 -> out_y=0 then 1, each one cycle after transfer; hit_cnt=1.
REQ-034 N_IN=8, mode=010, in_data=8'hA7 -> out_y=1; mode=011, in_data=8'hFF -> out_y=0; mode=100, in_data=8'h00 -> out_y=1.
REQ-035 Hold out_ready=0 for 5 cycles with in_valid=1 and changing in_data -> in_ready=0, out_y stable, exactly one result delivered when out_ready rises.
REQ-036 mode=111, in_data=3'b111 -> out_y=0, out_err=1, hit_cnt unchanged.
REQ-037 CNT_W=4, 20 back-to-back OR results of 1 -> hit_cnt stops at 15; then cnt_clr=1 with a concurrent hit -> hit_cnt=0.
REQ-038 Assert rst_n=0 between clock edges while out_valid=1 -> out_valid, out_y, hit_cnt go to 0 without a clock edge; in_ready=1.
